// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequencer for a single dot product of length L on the shared MAC
// accumulator. On an accepted Start it clears the accumulator. It then
// streams L operand pairs from a dual-word operand memory (1-cycle read
// latency) into the MAC. Next it captures the MAC output and offers the
// result over a valid/ready handshake.
//
// Ports:
//   Clk_CI, Rst_RI          clock, synchronous active-high reset
//   Start_SI, Len_DI        start request and vector length (sampled in IDLE)
//   Abort_SI                abandon the current operation
//   Busy_SO                 high whenever the sequencer is not IDLE
//   RdEn_SO, RdAddr_DO      operand memory read port
//   RdData0_DI, RdData1_DI  operand pair, valid one cycle after RdEn_SO
//   MacClr_SO, MacWrEn_SO   MAC control strobes
//   MacIn0_DO, MacIn1_DO    MAC operands
//   MacOut_DI               MAC output (upper WIDTH bits of the sum)
//   Result_DO, Valid_SO     captured dot product and its valid flag
//   Ready_SI                result consumer ready
module mac_seq_ctrl #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RI,
   input  logic                  Start_SI,
   input  logic [ADDR_WIDTH:0]   Len_DI,
   input  logic                  Abort_SI,
   output logic                  Busy_SO,
   output logic                  RdEn_SO,
   output logic [ADDR_WIDTH-1:0] RdAddr_DO,
   input  logic [WIDTH-1:0]      RdData0_DI,
   input  logic [WIDTH-1:0]      RdData1_DI,
   output logic                  MacClr_SO,
   output logic                  MacWrEn_SO,
   output logic [WIDTH-1:0]      MacIn0_DO,
   output logic [WIDTH-1:0]      MacIn1_DO,
   input  logic [WIDTH-1:0]      MacOut_DI,
   output logic [WIDTH-1:0]      Result_DO,
   output logic                  Valid_SO,
   input  logic                  Ready_SI
);

   localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, LAST, CAPTURE, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   len_q;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  mac_clr;
   logic                  mac_wr_en;
   logic [WIDTH-1:0]      result;
   logic                  valid;
   logic                  last_addr;

   function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

   // Address L-1 is being issued in this cycle.
   assign last_addr = ({1'b0, rd_addr} == (len_q - LEN_ONE));

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state     <= IDLE;
         len_q     <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         mac_clr   <= 1'b0;
         mac_wr_en <= 1'b0;
         result    <= '0;
         valid     <= 1'b0;
      end else if (Abort_SI && state != IDLE) begin
         // Abort wins over Ready; the last reported result is kept.
         state     <= IDLE;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         mac_clr   <= 1'b0;
         mac_wr_en <= 1'b0;
         valid     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Abort in IDLE also suppresses a simultaneous Start.
               if (Start_SI && !Abort_SI) begin
                  if (Len_DI == '0) begin
                     state  <= DONE;
                     result <= '0;
                     valid  <= 1'b1;
                  end else begin
                     state     <= CLEAR;
                     len_q     <= clamp_len(Len_DI);
                     mac_clr   <= 1'b1;
                     mac_wr_en <= 1'b1;
                     rd_en     <= 1'b1;
                     rd_addr   <= '0;
                  end
               end
            end
            CLEAR: begin
               mac_clr <= 1'b0;
               if (len_q == LEN_ONE) begin
                  state <= LAST;
                  rd_en <= 1'b0;
               end else begin
                  state   <= RUN;
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            RUN: begin
               if (last_addr) begin
                  state <= LAST;
                  rd_en <= 1'b0;
               end else begin
                  rd_addr <= rd_addr + 1'b1;
               end
            end
            LAST: begin
               state     <= CAPTURE;
               mac_wr_en <= 1'b0;
            end
            CAPTURE: begin
               // MAC operands are zero and WrEn is low, so MacOut is the sum.
               state  <= DONE;
               result <= MacOut_DI;
               valid  <= 1'b1;
            end
            DONE: begin
               if (Ready_SI) begin
                  state <= IDLE;
                  valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy_SO    = (state != IDLE);
   assign RdEn_SO    = rd_en;
   assign RdAddr_DO  = rd_addr;
   assign MacClr_SO  = mac_clr;
   assign MacWrEn_SO = mac_wr_en;
   assign Result_DO  = result;
   assign Valid_SO   = valid;

   // Read data arrives one cycle after RdEn, aligned with the data-phase
   // WrEn pulses. The clear cycle carries zero operands.
   assign MacIn0_DO = (mac_wr_en && !mac_clr) ? RdData0_DI : '0;
   assign MacIn1_DO = (mac_wr_en && !mac_clr) ? RdData1_DI : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;
   localparam int W    = 8;
   localparam int AW   = 4;
   localparam int MAXL = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, start = 1'b0, abort = 1'b0, ready = 1'b0;
   logic [AW:0]   len = '0;
   logic          busy, rd_en, mac_clr, mac_wr_en, valid;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd0 = '0, rd1 = '0;
   logic [W-1:0]  mac_in0, mac_in1, mac_out, result;

   logic [W-1:0]   mem_a [MAXL];
   logic [W-1:0]   mem_b [MAXL];
   logic [2*W-1:0] acc = '0;

   int checks = 0;
   int failures = 0;

   logic mon_clr = 1'b0;
   int   rd_cnt = 0, wr_cnt = 0, clr_cnt = 0, addr_err = 0;

   mac_seq_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .Len_DI(len),
      .Abort_SI(abort), .Busy_SO(busy), .RdEn_SO(rd_en), .RdAddr_DO(rd_addr),
      .RdData0_DI(rd0), .RdData1_DI(rd1), .MacClr_SO(mac_clr),
      .MacWrEn_SO(mac_wr_en), .MacIn0_DO(mac_in0), .MacIn1_DO(mac_in1),
      .MacOut_DI(mac_out), .Result_DO(result), .Valid_SO(valid), .Ready_SI(ready)
   );

   // Operand memory with 1-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) begin
         rd0 <= mem_a[rd_addr];
         rd1 <= mem_b[rd_addr];
      end
   end

   // MAC: Clr loads zero, otherwise unsigned multiply-accumulate.
   always @(posedge clk) begin
      if (mac_wr_en) begin
         if (mac_clr) acc <= '0;
         else acc <= acc + ({{W{1'b0}}, mac_in0} * {{W{1'b0}}, mac_in1});
      end
   end
   assign mac_out = acc[2*W-1:W];

   // Activity monitor: read/write/clear pulse counts and address order.
   always @(posedge clk) begin
      if (mon_clr) begin
         rd_cnt <= 0; wr_cnt <= 0; clr_cnt <= 0; addr_err <= 0;
      end else begin
         if (rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_addr != rd_cnt[AW-1:0]) addr_err <= addr_err + 1;
         end
         if (mac_wr_en && !mac_clr) wr_cnt <= wr_cnt + 1;
         if (mac_clr) clr_cnt <= clr_cnt + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_op(input int l);
      mon_clr = 1'b1;
      len     = l[AW:0];
      start   = 1'b1;
      tick();
      start   = 1'b0;
      mon_clr = 1'b0;
   endtask

   // Returns the cycle (counted from the accept edge) at which Valid is seen.
   task automatic wait_valid(input int c0, output int cyc);
      cyc = c0;
      while (valid !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick();
      checks++; if ({busy, valid, rd_en, mac_clr, mac_wr_en} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {busy, valid, rd_en, mac_clr, mac_wr_en}); end
      checks++; if (rd_addr !== '0) begin failures++; $display("FAIL reset_rdaddr got=%h exp=0", rd_addr); end
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      checks++; if ({mac_in0, mac_in1} !== '0) begin failures++; $display("FAIL reset_macin got=%h exp=0", {mac_in0, mac_in1}); end
      rst = 1'b0; tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b exp=0", busy); end
   endtask

   task automatic test_len2();
      int cyc;
      mem_a[0] = 8'd16; mem_a[1] = 8'd16; mem_b[0] = 8'd16; mem_b[1] = 8'd32;
      ready = 1'b1;
      start_op(2);
      wait_valid(1, cyc);
      checks++; if (cyc !== 5) begin failures++; $display("FAIL len2_latency got=%0d exp=5", cyc); end
      checks++; if (result !== 8'h03) begin failures++; $display("FAIL len2_result got=%h exp=03", result); end
      checks++; if (wr_cnt !== 2) begin failures++; $display("FAIL len2_writes got=%0d exp=2", wr_cnt); end
      checks++; if (rd_cnt !== 2 || addr_err !== 0) begin failures++; $display("FAIL len2_reads got=%0d/%0d exp=2/0", rd_cnt, addr_err); end
      checks++; if (clr_cnt !== 1) begin failures++; $display("FAIL len2_clr got=%0d exp=1", clr_cnt); end
      tick();
      checks++; if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL len2_release got=%b exp=00", {valid, busy}); end
   endtask

   task automatic test_len1();
      int cyc;
      mem_a[0] = 8'd255; mem_b[0] = 8'd255;
      start_op(1);
      checks++; if ({mac_clr, mac_wr_en, rd_en} !== 3'b111 || rd_addr !== '0) begin failures++; $display("FAIL len1_clear got=%b/%h exp=111/0", {mac_clr, mac_wr_en, rd_en}, rd_addr); end
      tick();
      checks++; if ({mac_clr, mac_wr_en, rd_en} !== 3'b010) begin failures++; $display("FAIL len1_last got=%b exp=010", {mac_clr, mac_wr_en, rd_en}); end
      checks++; if (mac_in0 !== 8'd255 || mac_in1 !== 8'd255) begin failures++; $display("FAIL len1_macin got=%h/%h exp=ff/ff", mac_in0, mac_in1); end
      wait_valid(2, cyc);
      checks++; if (cyc !== 4) begin failures++; $display("FAIL len1_latency got=%0d exp=4", cyc); end
      checks++; if (result !== 8'hFE) begin failures++; $display("FAIL len1_result got=%h exp=fe", result); end
      checks++; if (wr_cnt !== 1 || rd_cnt !== 1) begin failures++; $display("FAIL len1_counts got=%0d/%0d exp=1/1", wr_cnt, rd_cnt); end
      tick();
   endtask

   task automatic test_len0();
      int cyc;
      start_op(0);
      wait_valid(1, cyc);
      checks++; if (valid !== 1'b1 || cyc > 2) begin failures++; $display("FAIL len0_latency got=%0d exp<=2", cyc); end
      checks++; if (result !== 8'h00) begin failures++; $display("FAIL len0_result got=%h exp=00", result); end
      checks++; if (rd_cnt !== 0 || wr_cnt !== 0 || clr_cnt !== 0) begin failures++; $display("FAIL len0_activity got=%0d/%0d/%0d exp=0/0/0", rd_cnt, wr_cnt, clr_cnt); end
      tick();
      checks++; if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL len0_release got=%b exp=00", {valid, busy}); end
   endtask

   task automatic test_backpressure();
      int cyc;
      // 100*50 + 200*250 = 55000 = 0xD6D8
      mem_a[0] = 8'd100; mem_a[1] = 8'd200; mem_b[0] = 8'd50; mem_b[1] = 8'd250;
      ready = 1'b0;
      start_op(2);
      wait_valid(1, cyc);
      checks++; if (cyc !== 5 || result !== 8'hD6) begin failures++; $display("FAIL bp_first got=%0d/%h exp=5/d6", cyc, result); end
      for (int i = 0; i < 10; i++) begin
         start = (i == 3 || i == 6);
         len   = 5'd1;
         tick();
         checks++; if (valid !== 1'b1 || result !== 8'hD6) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/d6", i, valid, result); end
      end
      start = 1'b0;
      checks++; if (rd_cnt !== 2) begin failures++; $display("FAIL bp_start_ignored got=%0d exp=2", rd_cnt); end
      ready = 1'b1; start = 1'b1; len = 5'd1;
      tick();
      start = 1'b0;
      checks++; if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL bp_release got=%b exp=00", {valid, busy}); end
      tick();
      checks++; if (busy !== 1'b0 || rd_cnt !== 2) begin failures++; $display("FAIL bp_handshake_start got=%b/%0d exp=0/2", busy, rd_cnt); end
   endtask

   task automatic test_abort();
      int  cyc;
      bool_t_dummy: begin end
      for (int i = 0; i < 8; i++) begin mem_a[i] = 8'(i + 1); mem_b[i] = 8'd1; end
      start_op(8);
      cyc = 0;
      while (!(rd_en === 1'b1 && rd_addr === 4'd3) && cyc < 20) begin tick(); cyc++; end
      checks++; if (cyc >= 20) begin failures++; $display("FAIL abort_reach got=timeout exp=addr3"); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if ({busy, rd_en, mac_wr_en, mac_clr, valid} !== 5'b0) begin failures++; $display("FAIL abort_strobes got=%b exp=00000", {busy, rd_en, mac_wr_en, mac_clr, valid}); end
      checks++; if (result !== 8'hD6) begin failures++; $display("FAIL abort_result_kept got=%h exp=d6", result); end
      cyc = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (valid !== 1'b0 || busy !== 1'b0) cyc++; end
      checks++; if (cyc !== 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", cyc); end
      abort = 1'b1; start = 1'b1; len = 5'd2;
      tick();
      abort = 1'b0; start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_start got=%b exp=0", busy); end
      mem_a[0] = 8'd16; mem_a[1] = 8'd16; mem_b[0] = 8'd16; mem_b[1] = 8'd32;
      start_op(2);
      wait_valid(1, cyc);
      checks++; if (cyc !== 5 || result !== 8'h03) begin failures++; $display("FAIL abort_restart got=%0d/%h exp=5/03", cyc, result); end
      tick();
   endtask

   task automatic test_maxlen();
      int cyc;
      for (int i = 0; i < MAXL; i++) begin mem_a[i] = 8'd16; mem_b[i] = 8'd16; end
      start_op(MAXL + 1);
      wait_valid(1, cyc);
      checks++; if (cyc !== MAXL + 3) begin failures++; $display("FAIL max_latency got=%0d exp=%0d", cyc, MAXL + 3); end
      checks++; if (result !== 8'h10) begin failures++; $display("FAIL max_result got=%h exp=10", result); end
      checks++; if (rd_cnt !== MAXL || addr_err !== 0) begin failures++; $display("FAIL max_reads got=%0d/%0d exp=%0d/0", rd_cnt, addr_err, MAXL); end
      checks++; if (wr_cnt !== MAXL || clr_cnt !== 1) begin failures++; $display("FAIL max_writes got=%0d/%0d exp=%0d/1", wr_cnt, clr_cnt, MAXL); end
      tick();
   endtask

   task automatic test_reset_mid();
      int bad;
      start_op(8);
      tick(); tick(); tick();
      checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL rstmid_running got=%b exp=1", rd_en); end
      rst = 1'b1; tick();
      checks++; if ({busy, valid, rd_en, mac_clr, mac_wr_en} !== 5'b0) begin failures++; $display("FAIL rstmid_strobes got=%b exp=00000", {busy, valid, rd_en, mac_clr, mac_wr_en}); end
      checks++; if (rd_addr !== '0 || result !== '0 || {mac_in0, mac_in1} !== '0) begin failures++; $display("FAIL rstmid_data got=%h/%h/%h exp=0/0/0", rd_addr, result, {mac_in0, mac_in1}); end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (valid !== 1'b0 || busy !== 1'b0) bad++; end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=0", bad); end
   endtask

   initial begin
      for (int i = 0; i < MAXL; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      test_reset();
      test_len2();
      test_len1();
      test_len0();
      test_backpressure();
      test_abort();
      test_maxlen();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
